// File: rtl/floo_atop_rsp_tracker_pkg.sv
// ============================================================================
// Module   : floo_atop_rsp_tracker_pkg
// Purpose  : Shared constants and the lowest-pending-slot search helper used
//            by the atomic response tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package floo_atop_rsp_tracker_pkg;

  // Upper bound on atomic slots the priority search can cover.
  localparam int unsigned MaxSlotsLimit = 32;

  typedef logic [MaxSlotsLimit-1:0] slot_vec_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned lowest_set(input slot_vec_t vec);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxSlotsLimit; i++) begin
      if (vec[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/floo_atop_rsp_tracker_if.sv
// ============================================================================
// Module   : floo_atop_rsp_tracker_if
// Purpose  : B response path, R monitor tap and meta-buffer pop/lookup port
//            seen by the atomic response tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface floo_atop_rsp_tracker_if #(
  parameter type id_t = logic
);

  // B response: unpacker side in, AXI side out
  logic b_valid_i;
  id_t  b_id_i;
  logic b_ready_o;
  logic b_valid_o;
  logic b_ready_i;

  // R beat monitor tap
  logic r_valid_i;
  logic r_ready_i;
  logic r_last_i;
  id_t  r_id_i;

  // Meta buffer pop / lookup port
  logic meta_pop_o;
  id_t  meta_id_o;

  // Tracker view
  modport slave (
    input  b_valid_i, b_id_i, b_ready_i,
    input  r_valid_i, r_ready_i, r_last_i, r_id_i,
    output b_ready_o, b_valid_o, meta_pop_o, meta_id_o
  );

  // Environment view
  modport master (
    output b_valid_i, b_id_i, b_ready_i,
    output r_valid_i, r_ready_i, r_last_i, r_id_i,
    input  b_ready_o, b_valid_o, meta_pop_o, meta_id_o
  );

endinterface

`default_nettype wire

// File: rtl/floo_atop_slot.sv
// ============================================================================
// Module   : floo_atop_slot
// Purpose  : One atomic slot: B-done and R-done flags with set, clear and
//            double-set error detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module floo_atop_slot (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic set_b_i,
  input  logic set_r_i,
  input  logic clr_i,
  output logic b_done_o,
  output logic r_done_o,
  output logic err_o
);

  logic b_done_q;
  logic r_done_q;

  // Flag pair; a clear takes the incoming set so a popped slot can be
  // re-armed in the very cycle it is freed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_done_q <= 1'b0;
      r_done_q <= 1'b0;
    end else begin
      if (clr_i) begin
        b_done_q <= set_b_i;
        r_done_q <= set_r_i;
      end else begin
        if (set_b_i) b_done_q <= 1'b1;
        if (set_r_i) r_done_q <= 1'b1;
      end
    end
  end

  // Setting a flag that is already set (and not being freed) is a protocol
  // error; the flag simply stays set.
  assign err_o    = !clr_i && ((set_b_i && b_done_q) || (set_r_i && r_done_q));
  assign b_done_o = b_done_q;
  assign r_done_o = r_done_q;

endmodule

`default_nettype wire

// File: rtl/floo_atop_rsp_tracker.sv
// ============================================================================
// Module   : floo_atop_rsp_tracker
// Purpose  : Releases meta-buffer entries: non-atomic B responses pop on the
//            B handshake, atomic slots pop one cycle after both their B and
//            last R beat completed. Owns and arbitrates the single pop port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module floo_atop_rsp_tracker
  import floo_atop_rsp_tracker_pkg::*;
#(
  parameter bit          AtopSupport   = 1'b1,
  // Must not exceed MaxSlotsLimit; ID width is assumed to be at most 32 bits.
  parameter int unsigned MaxAtomicTxns = 1,
  parameter type         id_t          = logic
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  floo_atop_rsp_tracker_if.slave  bus,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam id_t NonAtomicId = '1;

  if (AtopSupport) begin : g_atop

    logic [MaxAtomicTxns-1:0] b_done_q;
    logic [MaxAtomicTxns-1:0] r_done_q;
    logic [MaxAtomicTxns-1:0] pend;
    logic [MaxAtomicTxns-1:0] b_set;
    logic [MaxAtomicTxns-1:0] r_set;
    logic [MaxAtomicTxns-1:0] clr;
    logic [MaxAtomicTxns-1:0] slot_err;
    slot_vec_t                pend_ext;
    int unsigned              pend_idx;
    logic                     defer;
    logic                     b_hs;
    logic                     r_last_hs;
    logic                     b_atomic;
    logic                     r_atomic;
    logic                     b_in_range;
    logic                     r_in_range;
    logic                     id_err;
    logic                     err_q;

    assign pend     = b_done_q & r_done_q;
    assign defer    = |pend;
    assign pend_ext = slot_vec_t'(pend);
    assign pend_idx = lowest_set(pend_ext);

    // A pending atomic pop owns the meta port, so B is held off that cycle.
    assign bus.b_valid_o = bus.b_valid_i && !defer;
    assign bus.b_ready_o = bus.b_ready_i && !defer;

    assign b_hs      = bus.b_valid_i && bus.b_ready_i && !defer;
    assign r_last_hs = bus.r_valid_i && bus.r_ready_i && bus.r_last_i;

    assign b_atomic   = b_hs && (bus.b_id_i != NonAtomicId);
    assign r_atomic   = r_last_hs && (bus.r_id_i != NonAtomicId);
    assign b_in_range = 32'(bus.b_id_i) < MaxAtomicTxns;
    assign r_in_range = 32'(bus.r_id_i) < MaxAtomicTxns;
    assign id_err     = (b_atomic && !b_in_range) || (r_atomic && !r_in_range);

    // Meta port: deferred atomic pop first, otherwise lookup for the live B.
    always_comb begin
      bus.meta_pop_o = 1'b0;
      bus.meta_id_o  = bus.b_id_i;
      if (defer) begin
        bus.meta_pop_o = 1'b1;
        bus.meta_id_o  = id_t'(pend_idx);
      end else if (b_hs && (bus.b_id_i == NonAtomicId)) begin
        bus.meta_pop_o = 1'b1;
      end
    end

    for (genvar i = 0; i < MaxAtomicTxns; i++) begin : g_slot
      assign b_set[i] = b_atomic && b_in_range && (32'(bus.b_id_i) == i);
      assign r_set[i] = r_atomic && r_in_range && (32'(bus.r_id_i) == i);
      assign clr[i]   = defer && (pend_idx == i);

      floo_atop_slot u_slot (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .set_b_i  (b_set[i]),
        .set_r_i  (r_set[i]),
        .clr_i    (clr[i]),
        .b_done_o (b_done_q[i]),
        .r_done_o (r_done_q[i]),
        .err_o    (slot_err[i])
      );
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        err_q <= 1'b0;
      end else if (id_err || (|slot_err)) begin
        err_q <= 1'b1;
      end
    end

    assign busy_o = |(b_done_q | r_done_q);
    assign err_o  = err_q;

  end else begin : g_passthrough

    logic unused_inputs;

    assign bus.b_valid_o  = bus.b_valid_i;
    assign bus.b_ready_o  = bus.b_ready_i;
    assign bus.meta_id_o  = bus.b_id_i;
    assign bus.meta_pop_o = bus.b_valid_i && bus.b_ready_i;
    assign busy_o         = 1'b0;
    assign err_o          = 1'b0;

    assign unused_inputs = ^{clk_i, rst_ni, bus.r_valid_i, bus.r_ready_i,
                             bus.r_last_i, bus.r_id_i};

  end

endmodule

`default_nettype wire

// File: tb/tb_floo_atop_rsp_tracker.sv
// ============================================================================
// Module   : tb_floo_atop_rsp_tracker
// Purpose  : Self-checking bench for the atomic response tracker (atomic
//            build with 4 slots and a passthrough build side by side).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_floo_atop_rsp_tracker;

  typedef logic [2:0] tid_t;
  localparam int NA    = 7;   // non-atomic ID ('1 on 3 bits)
  localparam int SLOTS = 4;

  logic clk;
  logic rst_n;
  logic busy1, err1, busy0, err0;

  floo_atop_rsp_tracker_if #(.id_t(tid_t)) bus1 ();
  floo_atop_rsp_tracker_if #(.id_t(tid_t)) bus0 ();

  floo_atop_rsp_tracker #(
    .AtopSupport   (1'b1),
    .MaxAtomicTxns (SLOTS),
    .id_t          (tid_t)
  ) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus1),
    .busy_o (busy1),
    .err_o  (err1)
  );

  floo_atop_rsp_tracker #(
    .AtopSupport   (1'b0),
    .MaxAtomicTxns (SLOTS),
    .id_t          (tid_t)
  ) u_dut_pt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus0),
    .busy_o (busy0),
    .err_o  (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: which completions each atomic transaction has seen so far.
  bit got_b [SLOTS];
  bit got_r [SLOTS];
  bit exp_err;

  // Values observed in the most recent step, for directed checks.
  int obs_pop, obs_id, obs_busy, obs_bvo, obs_bro, obs_err;
  int obs0_pop, obs0_id;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit bv, input int bid, input bit br,
                       input bit rv, input bit rr, input bit rl, input int rid);
    bus1.b_valid_i = bv;  bus0.b_valid_i = bv;
    bus1.b_id_i    = tid_t'(bid); bus0.b_id_i = tid_t'(bid);
    bus1.b_ready_i = br;  bus0.b_ready_i = br;
    bus1.r_valid_i = rv;  bus0.r_valid_i = rv;
    bus1.r_ready_i = rr;  bus0.r_ready_i = rr;
    bus1.r_last_i  = rl;  bus0.r_last_i  = rl;
    bus1.r_id_i    = tid_t'(rid); bus0.r_id_i = tid_t'(rid);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < SLOTS; i++) begin
      got_b[i] = 1'b0;
      got_r[i] = 1'b0;
    end
    exp_err = 1'b0;
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit bv, input int bid, input bit br,
                      input bit rv, input bit rr, input bit rl, input int rid);
    bit ready_slot;
    int first_ready;
    bit any_flag;
    bit e_bvo, e_bro, bhs, rhs, e_pop;
    int e_id;
    drive(bv, bid, br, rv, rr, rl, rid);
    ready_slot  = 1'b0;
    first_ready = 0;
    any_flag    = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (got_b[i] && got_r[i] && !ready_slot) begin
        ready_slot  = 1'b1;
        first_ready = i;
      end
      if (got_b[i] || got_r[i]) any_flag = 1'b1;
    end
    e_bvo = bv && !ready_slot;
    e_bro = br && !ready_slot;
    bhs   = e_bvo && br;
    rhs   = rv && rr && rl;
    e_pop = ready_slot || (bhs && bid == NA);
    e_id  = ready_slot ? first_ready : bid;

    @(negedge clk);
    obs_pop  = int'(bus1.meta_pop_o);
    obs_id   = int'(bus1.meta_id_o);
    obs_busy = int'(busy1);
    obs_bvo  = int'(bus1.b_valid_o);
    obs_bro  = int'(bus1.b_ready_o);
    obs_err  = int'(err1);
    obs0_pop = int'(bus0.meta_pop_o);
    obs0_id  = int'(bus0.meta_id_o);
    check_eq("b_valid_o", obs_bvo, int'(e_bvo));
    check_eq("b_ready_o", obs_bro, int'(e_bro));
    check_eq("meta_pop_o", obs_pop, int'(e_pop));
    check_eq("meta_id_o", obs_id, e_id);
    check_eq("busy_o", obs_busy, int'(any_flag));
    check_eq("err_o", obs_err, int'(exp_err));
    check_eq("pt_b_valid_o", int'(bus0.b_valid_o), int'(bv));
    check_eq("pt_b_ready_o", int'(bus0.b_ready_o), int'(br));
    check_eq("pt_meta_pop_o", obs0_pop, int'(bv && br));
    check_eq("pt_meta_id_o", obs0_id, bid);
    check_eq("pt_busy_o", int'(busy0), 0);
    check_eq("pt_err_o", int'(err0), 0);

    @(posedge clk);
    if (ready_slot) begin
      got_b[first_ready] = 1'b0;
      got_r[first_ready] = 1'b0;
    end
    if (bhs && bid != NA) begin
      if (bid >= SLOTS || got_b[bid]) exp_err = 1'b1;
      else got_b[bid] = 1'b1;
    end
    if (rhs && rid != NA) begin
      if (rid >= SLOTS || got_r[rid]) exp_err = 1'b1;
      else got_r[rid] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset in the middle of a cycle.
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy_o", int'(busy1), 0);
    check_eq("rst_err_o", int'(err1), 0);
    check_eq("rst_meta_pop_o", int'(bus1.meta_pop_o), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_id();
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 6) return r % SLOTS;
    if (r < 10) return NA;
    if (r == 10) return SLOTS + int'($urandom_range(0, 2));
    return int'($urandom_range(0, SLOTS - 1));
  endfunction

  initial begin
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy_o", int'(busy1), 0);
    check_eq("reset_err_o", int'(err1), 0);
    check_eq("reset_meta_pop_o", int'(bus1.meta_pop_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Non-atomic passthrough: zero-latency pop.
    step(1, NA, 1, 0, 0, 0, 0);
    check_eq("na_pop", obs_pop, 1);
    check_eq("na_id", obs_id, NA);
    check_eq("na_bvo", obs_bvo, 1);

    // B id 2, later R-last id 2, pop one cycle after the R-last.
    step(1, 2, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      idle();
      check_eq("bthenr_busy", obs_busy, 1);
      check_eq("bthenr_nopop", obs_pop, 0);
    end
    step(0, 0, 0, 1, 1, 1, 2);
    idle();
    check_eq("bthenr_pop", obs_pop, 1);
    check_eq("bthenr_id", obs_id, 2);
    check_eq("bthenr_busy_pop", obs_busy, 1);
    idle();
    check_eq("bthenr_busy_after", obs_busy, 0);

    // Simultaneous B and R-last on slot 1; non-atomic B stalled one cycle.
    step(1, 1, 1, 1, 1, 1, 1);
    step(1, NA, 1, 0, 0, 0, 0);
    check_eq("sim_pop", obs_pop, 1);
    check_eq("sim_id", obs_id, 1);
    check_eq("sim_bvo_stall", obs_bvo, 0);
    check_eq("sim_bro_stall", obs_bro, 0);
    step(1, NA, 1, 0, 0, 0, 0);
    check_eq("sim_na_id", obs_id, NA);
    check_eq("sim_na_bvo", obs_bvo, 1);

    // Slots 3 and 0 pending together: pop 0 then 3, B stalled on both.
    step(1, 3, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(1, 0, 1, 1, 1, 1, 3);
    step(1, NA, 1, 0, 0, 0, 0);
    check_eq("multi_id0", obs_id, 0);
    check_eq("multi_stall0", obs_bvo, 0);
    step(1, NA, 1, 0, 0, 0, 0);
    check_eq("multi_id3", obs_id, 3);
    check_eq("multi_stall3", obs_bvo, 0);
    step(1, NA, 1, 0, 0, 0, 0);
    check_eq("multi_na", obs_id, NA);
    check_eq("multi_busy", obs_busy, 0);

    // Double B on slot 2 is an error; reset drops the half-done slot.
    step(1, 2, 1, 0, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0);
    idle();
    check_eq("err_set", obs_err, 1);
    idle();
    check_eq("err_sticky", obs_err, 1);
    do_reset();
    step(0, 0, 0, 1, 1, 1, 2);
    idle();
    check_eq("rst_nopop", obs_pop, 0);
    check_eq("rst_err_clr", obs_err, 0);

    // Passthrough build: id 0 pops immediately.
    step(1, 0, 1, 0, 0, 0, 0);
    check_eq("pt_pop_id0", obs0_pop, 1);
    check_eq("pt_id0", obs0_id, 0);
    do_reset();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), pick_id(), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 2) == 0), pick_id());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
